// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and pulses bit_done on the last count.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic run,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done = run && (cnt_q == LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Serial transmit framer: start bit, 8 data bits LSB-first, optional parity, 1-2 stop bits.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam bit           PAR_EN   = (PARITY_EN != 0);
    localparam bit           PAR_ODD  = (PARITY_ODD != 0);
    localparam bit           TWO_STOP = (STOP_BITS == 2);
    localparam logic [2:0]   LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q;
    logic [7:0]     shreg_q;
    logic [2:0]     bit_cnt_q;
    logic           stop_cnt_q;
    logic           parity_q;
    logic           accept;
    logic           bit_done;

    assign accept = tx_valid && tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (accept),
        .run     (busy),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shreg_q  <= tx_data;
                        parity_q <= (^tx_data) ^ PAR_ODD;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        tx        <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        // Counter wraps to 0 after the last data bit.
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PAR_EN) begin
                                tx      <= parity_q;
                                state_q <= StParity;
                            end else begin
                                tx         <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= StStop;
                            end
                        end else begin
                            tx      <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                end
                StParity: begin
                    if (bit_done) begin
                        tx         <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= StStop;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        if (!TWO_STOP || stop_cnt_q) begin
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit framer for `fpga_top`: accepts one byte at a time over a valid/ready handshake and shifts it out as an asynchronous serial frame (start, 8 data bits LSB-first, optional parity, 1–2 stop bits). It is the outbound counterpart to the stimulus side of the FPGA top bench. `fpga_top` uses it to report status and counter bytes off-chip on a single pin, and the bench decodes that pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, 104: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on accept.
- `tx_valid`  in  1  producer has a byte.
- `tx_ready`  out  1  framer can accept a byte (high only in IDLE).
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  frame in progress (not IDLE).

## Operation

- Reset values, forced asynchronously while `nrst` = 0: `tx` = 1, `busy` = 0, `tx_ready` = 1 (IDLE), bit counter = 0, baud counter = 0.
- A byte is accepted on a rising edge where `tx_valid && tx_ready`. `tx_data` is copied into the shift register and parity is computed from it.
- Later changes to `tx_data` have no effect on the frame in progress.
- `tx_valid` asserted while `tx_ready` = 0 is ignored. The producer holds it or retries; dropping `tx_valid` without an accept is legal.
- FSM states: IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- Each state holds `tx` for exactly `CLKS_PER_BIT` cycles per bit:
  - DATA loops 8 bits, LSB first.
  - STOP lasts `STOP_BITS` bits with `tx` = 1.
- Parity bit:
  - even: XOR of the 8 data bits;
  - odd: the inverse.
- `tx_ready` = 1 only in IDLE. `busy` = 0 only in IDLE.
- Reset asserted mid-frame aborts the frame immediately: `tx` returns high asynchronously and the byte is lost. After reset release the framer is in IDLE and the next frame is clean.
- Width rules:
  - baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`−1, wraps to 0 on each bit boundary;
  - bit counter is 3 bits and wraps after bit 7.

## Timing

- Let the accept edge be edge k, and let N = 1 + 8 + `PARITY_EN` + `STOP_BITS`, with C = `CLKS_PER_BIT`.
- Start bit: `tx` = 0 from edge k through edge k+C.
- Data bit i (0..7) is driven from edge k+(1+i)·C.
- Parity bit (if enabled) is driven from edge k+9·C.
- Stop bits are driven from edge k+(9+`PARITY_EN`)·C.
- The FSM returns to IDLE at edge k+N·C; `tx_ready` is high in the following cycle.
- The earliest next accept is edge k+N·C+1, so frame-to-frame spacing is N·C+1 cycles. The one-cycle idle-high gap is mandatory.
- Latency from accept to the start-bit falling edge is 0 cycles, since `tx` is registered on the accept edge.

## Structure

- Shared package `uart_pkg` holds:
  - typedef `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constant `UART_DATA_BITS` = 8.
- Sub-module `uart_baud_tick`, one instance:
  - counter with synchronous clear on accept;
  - emits a one-cycle `bit_done` pulse when the count reaches `CLKS_PER_BIT`−1.
- The FSM, shift register and parity logic live in `uart_tx_framer`.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4.

- **Reset:** hold `nrst` = 0 for 2 edges → `tx` = 1, `tx_ready` = 1, `busy` = 0 throughout and after release.
- **Single byte:** send 0xA5, no parity, 1 stop → `tx` = 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles; `tx_ready` returns high 40 cycles after accept.
- **Back-to-back:** 0x00 then 0xFF with `tx_valid` held continuously → second start bit begins exactly 41 cycles after the first accept; `tx` is high for one cycle between the frames.
- **Parity:** 0x07 with `PARITY_EN` = 1 → parity bit 1 when `PARITY_ODD` = 0, and 0 when `PARITY_ODD` = 1; frame length is 44 cycles.
- **Two stop bits:** 0x3C with `STOP_BITS` = 2 → `tx` is high for 8 cycles after data bit 7; `tx_ready` returns after 44 cycles.
- **Abort and ignore:**
  - assert `nrst` = 0 during data bit 3 → `tx` = 1 immediately;
  - a subsequent 0x5A frame is bit-exact;
  - `tx_valid` pulses and `tx_data` changes during a frame alter nothing on `tx`.
